// File: rtl/i2c_pmic_responder.sv
// I2C target standing in for the removed PMIC: 2^REG_AW x 8 register file, auto-incrementing
// pointer, write strobes and a host side port. Define I2C_RESP_TIMEOUT_EN for the SCL-idle timeout.
module i2c_pmic_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h4A,
  parameter int          REG_AW      = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  localparam int DEPTH = 1 << REG_AW;

  logic              scl_meta, scl_s, scl_d;
  logic              sda_meta, sda_s, sda_d;
  logic              scl_rise, scl_fall, start_det, stop_det, timeout_hit;
  state_t            state, state_d;
  logic [7:0]        shift;
  logic [3:0]        bit_cnt;
  logic              rw, mack_ok;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [DEPTH];
  logic [7:0]        rx_byte, rd_byte;
  logic              rx_bit, byte_done, reg_we;
  logic              ack_start, ack_end, rd_load, rd_shift, rd_done, mack_ack;

  // Synchronizers reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
      sda_meta <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_meta <= scl_in; scl_s <= scl_meta; scl_d <= scl_s;
      sda_meta <= sda_in; sda_s <= sda_meta; sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign busy      = (state != IDLE);
  assign rd_byte   = regs[ptr];

`ifdef I2C_RESP_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || scl_rise || scl_fall) begin
      idle_cnt <= 16'd0;
    end else if (idle_cnt != TIMEOUT_CYC) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout_hit = busy && (idle_cnt == TIMEOUT_CYC);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every output of this block gets a default before any branch, so no path leaves a
  // variable unassigned and no latch is inferred; combinational logic uses blocking '='.
  always_comb begin
    state_d   = state;
    rx_bit    = 1'b0;
    byte_done = 1'b0;
    reg_we    = 1'b0;
    ack_start = 1'b0;
    ack_end   = 1'b0;
    rd_load   = 1'b0;
    rd_shift  = 1'b0;
    rd_done   = 1'b0;
    mack_ack  = 1'b0;
    rx_byte   = {shift[6:0], sda_s};
    if (stop_det || timeout_hit) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_bit = 1'b1;
            if (bit_cnt == 4'd7) begin
              byte_done = 1'b1;
              case (state)
                ADDR:    state_d = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                PTR:     state_d = PTR_ACK;
                default: begin
                  state_d = WDATA_ACK;
                  reg_we  = 1'b1;
                end
              endcase
            end
          end
        end
        // sda_oe doubles as the ACK phase flag: first fall pulls SDA low, second releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              ack_start = 1'b1;
            end else begin
              ack_end = 1'b1;
              if (state == ADDR_ACK) begin
                state_d = rw ? RDATA : PTR;
                rd_load = rw;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              rd_done = 1'b1;
              state_d = RD_MACK;
            end else begin
              rd_shift = 1'b1;
            end
          end
        end
        RD_MACK: begin
          if (scl_rise) begin
            if (!sda_s) mack_ack = 1'b1;
            else        state_d  = IGNORE;
          end else if (scl_fall && mack_ok) begin
            rd_load = 1'b1;
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      shift     <= 8'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      mack_ok   <= 1'b0;
      ptr       <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det || timeout_hit) begin
        sda_oe  <= 1'b0;
        mack_ok <= 1'b0;
      end else if (start_det) begin
        bit_cnt <= 4'd0;
        mack_ok <= 1'b0;
      end else begin
        if (rx_bit) begin
          shift   <= rx_byte;
          bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
        end
        if (byte_done && state == ADDR) rw  <= rx_byte[0];
        if (byte_done && state == PTR)  ptr <= rx_byte[REG_AW-1:0];
        if (reg_we) begin
          wr_strobe <= 1'b1;
          wr_addr   <= ptr;
          wr_data   <= rx_byte;
          ptr       <= ptr + REG_AW'(1);
        end
        if (ack_start) sda_oe <= 1'b1;
        if (ack_end) begin
          sda_oe  <= 1'b0;
          bit_cnt <= 4'd0;
        end
        // The first read bit is placed on the same fall that ends the preceding ACK phase.
        if (rd_load) begin
          shift   <= {rd_byte[6:0], 1'b0};
          sda_oe  <= ~rd_byte[7];
          bit_cnt <= 4'd0;
          mack_ok <= 1'b0;
        end
        if (state == RDATA && scl_rise) bit_cnt <= bit_cnt + 4'd1;
        if (rd_shift) begin
          sda_oe <= ~shift[7];
          shift  <= {shift[6:0], 1'b0};
        end
        if (rd_done) begin
          sda_oe  <= 1'b0;
          bit_cnt <= 4'd0;
        end
        if (mack_ack) begin
          ptr     <= ptr + REG_AW'(1);
          mack_ok <= 1'b1;
        end
      end
    end
  end

  // NOTE: the register file is reset explicitly because software expects all-zero contents;
  // this rules out a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (reg_we)  regs[ptr]       <= rx_byte;
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_pmic_responder.sv
// Self-checking bench for i2c_pmic_responder: bit-banged I2C master, array model of the register
// file and pointer, and a strobe scoreboard. Expectations follow I2C_RESP_TIMEOUT_EN if defined.
module tb_i2c_pmic_responder;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 16;
  localparam int Q      = 8;

  logic       clk = 1'b0;
  logic       reset, scl_drv, sda_drv, sda_in, sda_oe, host_we, wr_strobe, busy;
  logic [3:0] host_addr, wr_addr;
  logic [7:0] host_wdata, host_rdata, wr_data;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  model_regs [DEPTH];
  logic [3:0]  model_ptr;
  logic [11:0] exp_q[$], obs_q[$];
  logic [7:0]  wr_bytes[$], rd_got[$];
  logic        oe_seen;

  always #5 clk = ~clk;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_pmic_responder #(.DEV_ADDR(7'h4A), .REG_AW(REG_AW), .TIMEOUT_CYC(16'd100)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_drv), .sda_in(sda_in), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_regs[i] = 8'h00;
    model_ptr = 4'h0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    wait_clk(1);
    host_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] v);
    host_addr = a;
    wait_clk(2);
    v = host_rdata;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  // pulse=1 raises host_we for exactly the clk on which the responder commits this bit's byte.
  task automatic bus_bit(input logic b, input logic pulse, output logic sampled);
    sda_drv = b; wait_clk(Q);
    scl_drv = 1'b1;
    if (pulse) begin
      wait_clk(2); host_we = 1'b1;
      wait_clk(1); host_we = 1'b0;
      wait_clk(Q - 3);
    end else begin
      wait_clk(Q);
    end
    sampled = sda_in;
    wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input logic pulse, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], pulse && (i == 0), s);
    bus_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] v, input logic master_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    bus_bit(~master_ack, 1'b0, s);
  endtask

  // Write transaction from wr_bytes; pulse_idx selects the data byte that collides with host_we.
  task automatic i2c_write(input logic [7:0] ptr_byte, input int pulse_idx, output int acks);
    logic a;
    acks = 0;
    bus_start();
    write_byte(8'h94, 1'b0, a); acks += a ? 1 : 0;
    write_byte(ptr_byte, 1'b0, a); acks += a ? 1 : 0;
    model_ptr = ptr_byte[3:0];
    for (int k = 0; k < wr_bytes.size(); k++) begin
      write_byte(wr_bytes[k], k == pulse_idx, a); acks += a ? 1 : 0;
      model_regs[model_ptr] = wr_bytes[k];
      exp_q.push_back({model_ptr, wr_bytes[k]});
      model_ptr = model_ptr + 4'd1;
    end
    bus_stop();
  endtask

  task automatic i2c_read(input logic [7:0] ptr_byte, input int n, input logic do_stop,
                          output int acks);
    logic a;
    logic [7:0] v;
    acks = 0;
    rd_got.delete();
    bus_start();
    write_byte(8'h94, 1'b0, a); acks += a ? 1 : 0;
    write_byte(ptr_byte, 1'b0, a); acks += a ? 1 : 0;
    bus_start();
    write_byte(8'h95, 1'b0, a); acks += a ? 1 : 0;
    for (int k = 0; k < n; k++) begin
      read_byte(v, k != n - 1);
      rd_got.push_back(v);
    end
    model_ptr = ptr_byte[3:0] + 4'(n - 1);
    if (do_stop) bus_stop();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
    wait_clk(4);
    reset = 1'b0;
    model_clear();
    wait_clk(1);
    checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
    checks++; if (wr_addr !== 4'h0)   begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== 8'h00)  begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    checks++; if (host_rdata !== 8'h00) begin failures++; $display("FAIL reset_host_rdata got=%h exp=00", host_rdata); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    for (int a = 0; a < DEPTH; a++) begin
      host_read(4'(a), v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_reg[%0d] got=%h exp=00", a, v); end
    end
  endtask

  task automatic test_write();
    int acks, n;
    logic [7:0] v;
    obs_q.delete(); exp_q.delete();
    wr_bytes = '{8'hA5, 8'h5A};
    i2c_write(8'h03, -1, acks);
    wait_clk(4);
    checks++; if (acks !== 4) begin failures++; $display("FAIL write_acks got=%0d exp=4", acks); end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 12'h3A5 || obs_q[1] !== 12'h45A) begin
      failures++; $display("FAIL write_strobes got_count=%0d exp (3,A5),(4,5A)", obs_q.size());
    end
    host_read(4'h4, v);
    checks++; if (v !== 8'h5A) begin failures++; $display("FAIL write_reg4 got=%h exp=5A", v); end
    obs_q.delete(); exp_q.delete();
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      wr_bytes.delete();
      for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
      i2c_write(8'($urandom), -1, acks);
      checks++; if (acks !== n + 2) begin failures++; $display("FAIL rand_write_acks got=%0d exp=%0d", acks, n + 2); end
    end
    wait_clk(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_write_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_write_strobe[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      host_read(4'(a), v);
      checks++; if (v !== model_regs[a]) begin failures++; $display("FAIL rand_write_reg[%0d] got=%h exp=%h", a, v, model_regs[a]); end
    end
  endtask

  task automatic test_read();
    int acks, n;
    logic [7:0] p;
    logic [3:0] idx;
    host_write(4'h2, 8'h3C);
    host_write(4'h3, 8'hC3);
    i2c_read(8'h02, 2, 1'b0, acks);
    wait_clk(2);
    checks++; if (acks !== 3) begin failures++; $display("FAIL read_acks got=%0d exp=3", acks); end
    checks++; if (rd_got[0] !== 8'h3C) begin failures++; $display("FAIL read_byte0 got=%h exp=3C", rd_got[0]); end
    checks++; if (rd_got[1] !== 8'hC3) begin failures++; $display("FAIL read_byte1 got=%h exp=C3", rd_got[1]); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_nack_release got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL read_busy_before_stop got=%b exp=1", busy); end
    bus_stop();
    wait_clk(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_stop got=%b exp=0", busy); end
    for (int it = 0; it < 4; it++) begin
      host_write(4'($urandom), 8'($urandom));
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      i2c_read(p, n, 1'b1, acks);
      checks++; if (acks !== 3) begin failures++; $display("FAIL rand_read_acks got=%0d exp=3", acks); end
      for (int k = 0; k < n; k++) begin
        idx = p[3:0] + 4'(k);
        checks++; if (rd_got[k] !== model_regs[idx]) begin
          failures++; $display("FAIL rand_read[%0d] ptr=%h got=%h exp=%h", k, idx, rd_got[k], model_regs[idx]);
        end
      end
    end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int acks;
    obs_q.delete();
    oe_seen = 1'b0;
    acks = 0;
    bus_start();
    write_byte(8'h90, 1'b0, a); acks += a ? 1 : 0;
    write_byte(8'h01, 1'b0, a); acks += a ? 1 : 0;
    write_byte(8'($urandom), 1'b0, a); acks += a ? 1 : 0;
    bus_stop();
    wait_clk(4);
    checks++; if (acks !== 0) begin failures++; $display("FAIL wrong_addr_acks got=%0d exp=0", acks); end
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL wrong_addr_sda_oe got=%b exp=0", oe_seen); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL wrong_addr_strobes got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_wrap();
    int acks;
    logic [7:0] d0, d1, v;
    obs_q.delete(); exp_q.delete();
    d0 = 8'($urandom); d1 = ~d0;
    wr_bytes = '{d0, d1};
    i2c_write(8'h0F, -1, acks);
    wait_clk(4);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {4'hF, d0} || obs_q[1] !== {4'h0, d1}) begin
      failures++; $display("FAIL wrap_strobes got_count=%0d exp (F,%h),(0,%h)", obs_q.size(), d0, d1);
    end
    host_read(4'hF, v);
    checks++; if (v !== d0) begin failures++; $display("FAIL wrap_regF got=%h exp=%h", v, d0); end
    host_read(4'h0, v);
    checks++; if (v !== d1) begin failures++; $display("FAIL wrap_reg0 got=%h exp=%h", v, d1); end
  endtask

  task automatic test_stop_mid();
    logic a, s;
    logic [3:0] p;
    logic [7:0] v;
    obs_q.delete();
    p = 4'($urandom);
    bus_start();
    write_byte(8'h94, 1'b0, a);
    write_byte({4'h0, p}, 1'b0, a);
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom), 1'b0, s);
    bus_stop();
    wait_clk(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_mid_busy got=%b exp=0", busy); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stop_mid_strobes got=%0d exp=0", obs_q.size()); end
    host_read(p, v);
    checks++; if (v !== model_regs[p]) begin failures++; $display("FAIL stop_mid_reg got=%h exp=%h", v, model_regs[p]); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic [3:0] p, q;
    logic [7:0] d, h, v;
    obs_q.delete(); exp_q.delete();
    p = 4'($urandom); d = 8'($urandom); h = ~d;
    host_addr = p; host_wdata = h;
    wr_bytes = '{d};
    i2c_write({4'h0, p}, 0, acks);
    host_read(p, v);
    checks++; if (v !== d) begin failures++; $display("FAIL collide_same_reg got=%h exp=%h", v, d); end
    q = p + 4'd5; d = 8'($urandom); h = 8'($urandom);
    host_addr = q; host_wdata = h;
    wr_bytes = '{d};
    i2c_write({4'h0, p}, 0, acks);
    model_regs[q] = h;
    host_read(p, v);
    checks++; if (v !== model_regs[p]) begin failures++; $display("FAIL collide_i2c_reg got=%h exp=%h", v, model_regs[p]); end
    host_read(q, v);
    checks++; if (v !== model_regs[q]) begin failures++; $display("FAIL collide_host_reg got=%h exp=%h", v, model_regs[q]); end
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      failures++; $display("FAIL collide_strobes got_count=%0d exp_count=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic s;
    logic [7:0] v;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(8'h94 >> i, 1'b0, s);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL reset_mid_ack_driven got=%b exp=1", sda_oe); end
    reset = 1'b1;
    wait_clk(1);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_mid_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    checks++;
    if (wr_strobe !== 1'b0 || wr_addr !== 4'h0 || wr_data !== 8'h00 || host_rdata !== 8'h00) begin
      failures++; $display("FAIL reset_mid_outputs got=%b/%h/%h/%h exp=0/0/00/00", wr_strobe, wr_addr, wr_data, host_rdata);
    end
    reset = 1'b0;
    model_clear();
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
    host_read(4'h4, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_mid_reg_cleared got=%h exp=00", v); end
  endtask

  task automatic test_timeout();
    logic a, s;
    logic exp_busy, exp_oe;
`ifdef I2C_RESP_TIMEOUT_EN
    exp_busy = 1'b0; exp_oe = 1'b0;
`else
    exp_busy = 1'b1; exp_oe = 1'b1;
`endif
    host_write(4'h6, 8'h00);
    bus_start();
    write_byte(8'h94, 1'b0, a);
    write_byte(8'h06, 1'b0, a);
    bus_start();
    write_byte(8'h95, 1'b0, a);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, 1'b0, s);
    wait_clk(95 - Q);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_early got=%b exp=1", busy); end
    wait_clk(55);
    checks++; if (busy !== exp_busy) begin failures++; $display("FAIL timeout_busy got=%b exp=%b", busy, exp_busy); end
    checks++; if (sda_oe !== exp_oe) begin failures++; $display("FAIL timeout_sda_oe got=%b exp=%b", sda_oe, exp_oe); end
    reset = 1'b1; wait_clk(2); reset = 1'b0;
    model_clear();
    scl_drv = 1'b1; sda_drv = 1'b1; wait_clk(Q);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_stop_mid();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_pmic_responder.md
Name: i2c_pmic_responder

Overview:
I2C target (responder) that answers the SoC in place of the removed PMIC.
- Decodes START/STOP and address frames on the oversampled bus, ACKs its device address, and maintains a register pointer and a 2^REG_AW x 8 register file.
- Returns register contents on master reads by driving SDA open-drain.
- Reports every master register write to the glitch controller on a strobe interface; host logic can preload or read registers through a side port.

Parameters:
DEV_ADDR, 7'h4A, 7-bit target address answered on the bus
REG_AW, 4, register pointer width; register file depth 2^REG_AW
TIMEOUT_CYC, 16'd50000, clk cycles of SCL inactivity before forced return to IDLE (only with I2C_RESP_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
scl_in  in  1  raw SCL from bus, asynchronous
sda_in  in  1  raw SDA from bus, asynchronous
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
host_addr  in  REG_AW  side-port register address
host_wdata  in  8  side-port write data
host_we  in  1  side-port write enable
host_rdata  out  8  reg[host_addr], registered, 1-cycle latency
wr_strobe  out  1  1-cycle pulse: master wrote a register
wr_addr  out  REG_AW  register written (valid with wr_strobe)
wr_data  out  8  value written (valid with wr_strobe)
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0, busy=0, pointer=0, all registers=8'h00, state=IDLE. Reset mid-transfer releases SDA the same cycle the reset is sampled.
- Input conditioning:
  - scl_in and sda_in each pass through 2-flop synchronizers plus one history flop.
  - Events are derived from synchronized values only: scl_rise, scl_fall, START (SDA 1->0 while SCL=1), STOP (SDA 0->1 while SCL=1).
  - Bus-to-decision latency is 3 clk.
- Bit handling:
  - Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register with a 4-bit bit counter.
  - sda_oe changes only on scl_fall, except that STOP and reset release it immediately.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
  - Any state, START: go to ADDR, clear bit counter. The pointer is kept (repeated-start read).
  - Any state, STOP: go to IDLE, sda_oe=0.
  - ADDR: after 8 bits, compare bits[7:1] with DEV_ADDR.
    - Match: go to ADDR_ACK and latch the R/W bit.
    - Mismatch: go to IGNORE; sda_oe stays 0 until the next START or STOP.
  - ADDR_ACK: sda_oe=1 from the next scl_fall to the following scl_fall.
    - Write (R/W=0): then go to PTR.
    - Read (R/W=1): then go to RDATA, loading the shift register with reg[pointer] on that same scl_fall.
  - PTR: after 8 bits, pointer = byte[REG_AW-1:0] (upper bits ignored); go to PTR_ACK (ACK as above), then WDATA.
  - WDATA: after 8 bits, write reg[pointer]. wr_strobe pulses 1 clk with wr_addr=pointer and wr_data=byte. pointer = pointer+1, wrapping mod 2^REG_AW. Go to WDATA_ACK (ACK), then back to WDATA.
  - RDATA: drive sda_oe = ~shift[7] on each scl_fall, shifting left. After the 8th bit is clocked, release SDA and go to RD_MACK.
  - RD_MACK: sample SDA on scl_rise.
    - 0 (ACK): pointer+1 (wrap); load the next byte on scl_fall; go to RDATA.
    - 1 (NACK): go to IGNORE.
- Side port:
  - Simultaneous host_we and I2C write to the same register in one cycle: the I2C write wins.
  - A host_we to a different register completes normally.
  - host_rdata reflects the post-write value one cycle after the write.
- The responder never drives SDA high and never stretches SCL.

Optional Feature:
I2C_RESP_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on any synchronized SCL edge and on IDLE.
  - While busy=1, the counter increments each clk.
  - On reaching TIMEOUT_CYC, the block forces IDLE and sda_oe=0 next cycle; the pointer and registers are unchanged.
- Undefined: no counter is instantiated; the block leaves non-IDLE states only on START, STOP or reset.

Test Plan:
- Master write 0x94 (addr 4A,W), 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes. wr_strobe twice: (3,A5), then (4,5A). host_addr=4 reads 8'h5A.
- Preload reg2=0x3C and reg3=0xC3 via host_we. Write 0x94, 0x02, repeated START, 0x95, read 2 bytes (ACK then NACK) -> SDA shows 3C then C3; sda_oe=0 after NACK; busy drops after STOP.
- Address 0x90 (addr 48) -> no ACK; sda_oe=0 through following bytes; no wr_strobe.
- REG_AW=4, write starting at pointer 0x0F with 2 data bytes -> writes land at 0x0F then 0x00 (wrap).
- STOP injected after 3 bits of WDATA -> state IDLE, no register change, no wr_strobe. Separately, reset asserted during ADDR_ACK -> sda_oe=0 the next cycle, all outputs at reset values.
- With I2C_RESP_TIMEOUT_EN and TIMEOUT_CYC=100, SCL held low 150 clk mid-RDATA -> sda_oe=0 and busy=0 at cycle 101. Without the macro, busy stays 1.
